// File: rtl/mem_load_dump_ctrl.sv
// Load/run/dump harness: streams a byte image into IM then DM with the CPU held in reset, runs the CPU, then dumps GPRs and DM as bytes.
// Latency: load writes land in the same cycle as the accepted byte; an RF dump byte is registered one cycle after its slot frees; a DM dump byte takes at most two cycles (one read bubble).
// Backpressure: in_ready is high only while loading; the dump holds out_data/out_valid stable until out_ready and stops fetching while the slot is occupied.
module mem_load_dump_ctrl #(
  parameter int IM_SIZE    = 1024,
  parameter int DM_SIZE    = 1024,
  parameter int GPR_SIZE   = 32,
  parameter int XLEN       = 32,
  parameter int RUN_CYCLES = 100
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_start,
  input  logic                        i_in_valid,
  input  logic [7:0]                  i_in_data,
  output logic                        o_in_ready,
  output logic                        o_im_we,
  output logic [$clog2(IM_SIZE)-1:0]  o_im_addr,
  output logic [7:0]                  o_im_wdata,
  output logic                        o_dm_we,
  output logic [$clog2(DM_SIZE)-1:0]  o_dm_addr,
  output logic [7:0]                  o_dm_wdata,
  input  logic [7:0]                  i_dm_rdata,
  output logic [$clog2(GPR_SIZE)-1:0] o_rf_addr,
  input  logic [XLEN-1:0]             i_rf_rdata,
  output logic                        o_cpu_rst_n,
  output logic                        o_cpu_stall,
  input  logic                        i_cpu_halt,
  output logic                        o_out_valid,
  output logic [7:0]                  o_out_data,
  input  logic                        i_out_ready,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_timeout
);

  localparam int IAW      = $clog2(IM_SIZE);
  localparam int DAW      = $clog2(DM_SIZE);
  localparam int RAW      = $clog2(GPR_SIZE);
  localparam int BPR      = XLEN / 8;
  localparam int RF_BYTES = GPR_SIZE * BPR;
  localparam int MAX_A    = (IM_SIZE > DM_SIZE) ? IM_SIZE : DM_SIZE;
  localparam int MAX_B    = (RF_BYTES > RUN_CYCLES) ? RF_BYTES : RUN_CYCLES;
  localparam int MAXC     = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW       = $clog2(MAXC + 1);
  localparam int BSW      = (BPR > 1) ? $clog2(BPR) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_IM, S_LOAD_DM, S_RUN, S_DUMP_RF, S_DUMP_DM, S_DONE
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [RAW-1:0]   r_rf_addr;
  logic [BSW-1:0]   r_bsel;
  logic [DAW-1:0]   r_dm_raddr;
  logic             r_rd_vld;
  logic             r_in_ready;
  logic             r_cpu_rst_n;
  logic             r_cpu_stall;
  logic             r_busy;
  logic             r_done;
  logic             r_timeout;
  logic             r_out_valid;
  logic [7:0]       r_out_data;

  logic             w_load_fire;
  logic             w_slot_free;
  logic [7:0]       w_rf_byte;

  assign w_load_fire = i_in_valid & r_in_ready;
  assign w_slot_free = ~r_out_valid | i_out_ready;

  // Load writes are driven straight from the accepted byte so they land in the same cycle.
  assign o_im_we     = w_load_fire & (r_state == S_LOAD_IM);
  assign o_im_addr   = r_cnt[IAW-1:0];
  assign o_im_wdata  = i_in_data;
  assign o_dm_we     = w_load_fire & (r_state == S_LOAD_DM);
  assign o_dm_addr   = (r_state == S_LOAD_DM) ? r_cnt[DAW-1:0] : r_dm_raddr;
  assign o_dm_wdata  = i_in_data;
  assign o_rf_addr   = r_rf_addr;
  assign o_in_ready  = r_in_ready;
  assign o_cpu_rst_n = r_cpu_rst_n;
  assign o_cpu_stall = r_cpu_stall;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_timeout   = r_timeout;

  // Select the little-endian byte of the current register being dumped.
  always_comb begin
    w_rf_byte = '0;
    for (int b = 0; b < BPR; b++) begin
      if (r_bsel == BSW'(b)) w_rf_byte = i_rf_rdata[b*8 +: 8];
    end
  end

  // Sequencer: load -> run -> dump, with all control outputs registered alongside the state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rf_addr   <= '0;
      r_bsel      <= '0;
      r_dm_raddr  <= '0;
      r_rd_vld    <= 1'b0;
      r_in_ready  <= 1'b0;
      r_cpu_rst_n <= 1'b0;
      r_cpu_stall <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      // A completed transfer frees the output slot unless a new byte is loaded below.
      if (r_out_valid && i_out_ready) r_out_valid <= 1'b0;

      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state     <= S_LOAD_IM;
            r_cnt       <= '0;
            r_timeout   <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_cpu_rst_n <= 1'b0;
            r_cpu_stall <= 1'b1;
          end
        end

        S_LOAD_IM: begin
          if (w_load_fire) begin
            if (r_cnt == CW'(IM_SIZE - 1)) begin
              r_state <= S_LOAD_DM;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        S_LOAD_DM: begin
          if (w_load_fire) begin
            if (r_cnt == CW'(DM_SIZE - 1)) begin
              r_state     <= S_RUN;
              r_cnt       <= '0;
              r_in_ready  <= 1'b0;
              r_cpu_rst_n <= 1'b1;
              r_cpu_stall <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        S_RUN: begin
          // Halt takes priority over budget expiry in the same cycle.
          if (i_cpu_halt || (r_cnt == CW'(RUN_CYCLES - 1))) begin
            r_state     <= S_DUMP_RF;
            r_timeout   <= ~i_cpu_halt;
            r_cpu_stall <= 1'b1;
            r_cnt       <= '0;
            r_rf_addr   <= '0;
            r_bsel      <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DUMP_RF: begin
          if (w_slot_free) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_rf_byte;
            if (r_bsel == BSW'(BPR - 1)) begin
              r_bsel    <= '0;
              r_rf_addr <= r_rf_addr + 1'b1;
            end else begin
              r_bsel <= r_bsel + 1'b1;
            end
            if (r_cnt == CW'(RF_BYTES - 1)) begin
              r_state    <= S_DUMP_DM;
              r_cnt      <= '0;
              r_dm_raddr <= '0;
              r_rd_vld   <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        S_DUMP_DM: begin
          if (r_cnt == CW'(DM_SIZE)) begin
            // All bytes fetched; finish once the last one has left the slot.
            if (w_slot_free) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end
          end else if (r_rd_vld && w_slot_free) begin
            r_out_valid <= 1'b1;
            r_out_data  <= i_dm_rdata;
            r_cnt       <= r_cnt + 1'b1;
            r_dm_raddr  <= r_dm_raddr + 1'b1;
            r_rd_vld    <= 1'b0;
          end else begin
            // Address has been stable for a cycle, so read data matches it.
            r_rd_vld <= 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_load_dump_ctrl.sv
module tb_mem_load_dump_ctrl;
  localparam int IM    = 8;
  localparam int DM    = 8;
  localparam int GPR   = 4;
  localparam int XL    = 32;
  localparam int RC    = 20;
  localparam int RFB   = GPR * XL / 8;
  localparam int NDUMP = RFB + DM;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        im_we;
  logic [2:0]  im_addr;
  logic [7:0]  im_wdata;
  logic        dm_we;
  logic [2:0]  dm_addr;
  logic [7:0]  dm_wdata;
  logic [7:0]  dm_rdata = 8'h00;
  logic [1:0]  rf_addr;
  logic [31:0] rf_rdata;
  logic        cpu_rst_n;
  logic        cpu_stall;
  logic        cpu_halt = 1'b0;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        done;
  logic        timeout;

  always #5 clk = ~clk;

  mem_load_dump_ctrl #(
    .IM_SIZE(IM), .DM_SIZE(DM), .GPR_SIZE(GPR), .XLEN(XL), .RUN_CYCLES(RC)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(in_ready),
    .o_im_we(im_we), .o_im_addr(im_addr), .o_im_wdata(im_wdata),
    .o_dm_we(dm_we), .o_dm_addr(dm_addr), .o_dm_wdata(dm_wdata), .i_dm_rdata(dm_rdata),
    .o_rf_addr(rf_addr), .i_rf_rdata(rf_rdata),
    .o_cpu_rst_n(cpu_rst_n), .o_cpu_stall(cpu_stall), .i_cpu_halt(cpu_halt),
    .o_out_valid(out_valid), .o_out_data(out_data), .i_out_ready(out_ready),
    .o_busy(busy), .o_done(done), .o_timeout(timeout)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Memory and register-file models
  logic [7:0] im_mem [IM];
  logic [7:0] dm_mem [DM];
  int         im_wr_cnt = 0;
  int         dm_wr_cnt = 0;
  int         first_im_addr = -1;
  int         run_cnt = 0;
  int         halt_at = -1;
  logic       hold_pend = 1'b0;
  logic [7:0] hold_dat = 8'h00;
  logic [7:0] dump_q [$];

  assign rf_rdata = 32'h11223300 + 32'(rf_addr);

  always @(posedge clk) dm_rdata <= dm_mem[dm_addr];

  // Observe the settled cycle on the falling edge
  always @(negedge clk) begin
    if (im_we) begin
      im_mem[im_addr] = im_wdata;
      if (im_wr_cnt == 0) first_im_addr = int'(im_addr);
      im_wr_cnt++;
    end
    if (dm_we) begin
      dm_mem[dm_addr] = dm_wdata;
      dm_wr_cnt++;
    end
    if (cpu_rst_n === 1'b1 && cpu_stall === 1'b0) run_cnt++;
    if (hold_pend) begin
      check_val("hold_valid", 32'(out_valid), 32'd1);
      check_val("hold_data", 32'(out_data), 32'(hold_dat));
    end
    hold_pend = out_valid && !out_ready;
    hold_dat  = out_data;
    if (out_valid && out_ready) dump_q.push_back(out_data);
  end

  // Random sink backpressure and the CPU halt model
  always @(posedge clk) begin
    #1;
    out_ready = 1'($urandom_range(0, 1));
    cpu_halt  = (halt_at >= 0) && (cpu_rst_n === 1'b1) && (cpu_stall === 1'b0) && (run_cnt == halt_at);
  end

  task automatic stream(input int n);
    int idx = 0;
    int guard = 0;
    while (idx < n && guard < 1000) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = 8'(idx);
      end
      if (in_valid && in_ready) idx++;
      guard++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_val("stream_bytes", 32'(idx), 32'(n));
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("done_reached", 32'(done), 32'd1);
  endtask

  task automatic check_dump(input string tag);
    check_val({tag, "_len"}, 32'(dump_q.size()), 32'(NDUMP));
    for (int k = 0; k < NDUMP && k < dump_q.size(); k++) begin
      logic [7:0] e;
      if (k < RFB) begin
        case (k % 4)
          0:       e = 8'(k / 4);
          1:       e = 8'h33;
          2:       e = 8'h22;
          default: e = 8'h11;
        endcase
      end else begin
        e = 8'hA0 + 8'(k - RFB);
      end
      check_val($sformatf("%s_b%0d", tag, k), 32'(dump_q[k]), 32'(e));
    end
  endtask

  task automatic do_run(input int h, input int exp_cycles, input logic exp_to,
                        input string tag, input bit pulse_start);
    halt_at = -1;
    run_cnt = 0;
    dump_q.delete();
    im_wr_cnt = 0;
    dm_wr_cnt = 0;
    first_im_addr = -1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_val({tag, "_st_busy"}, 32'(busy), 32'd1);
    check_val({tag, "_st_done"}, 32'(done), 32'd0);
    check_val({tag, "_st_timeout"}, 32'(timeout), 32'd0);
    check_val({tag, "_st_inrdy"}, 32'(in_ready), 32'd1);
    check_val({tag, "_st_cpurst"}, 32'(cpu_rst_n), 32'd0);
    halt_at = h;
    stream(IM + DM);
    check_val({tag, "_run_inrdy"}, 32'(in_ready), 32'd0);
    check_val({tag, "_run_cpurst"}, 32'(cpu_rst_n), 32'd1);
    check_val({tag, "_run_stall"}, 32'(cpu_stall), 32'd0);
    check_val({tag, "_im_first"}, 32'(first_im_addr), 32'd0);
    for (int k = 0; k < IM; k++) check_val($sformatf("%s_im%0d", tag, k), 32'(im_mem[k]), 32'(k));
    for (int k = 0; k < DM; k++) check_val($sformatf("%s_dm%0d", tag, k), 32'(dm_mem[k]), 32'(8 + k));
    // The program rewrites DM while running
    for (int k = 0; k < DM; k++) dm_mem[k] = 8'hA0 + 8'(k);
    // Stray bytes outside the load phase must not be written
    in_valid = 1'b1;
    in_data  = 8'hEE;
    if (pulse_start) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done();
    check_val({tag, "_run_cycles"}, 32'(run_cnt), 32'(exp_cycles));
    check_val({tag, "_timeout"}, 32'(timeout), 32'(exp_to));
    check_val({tag, "_busy_done"}, 32'(busy), 32'd0);
    check_val({tag, "_stall_done"}, 32'(cpu_stall), 32'd1);
    check_val({tag, "_cpurst_done"}, 32'(cpu_rst_n), 32'd1);
    check_val({tag, "_im_writes"}, 32'(im_wr_cnt), 32'(IM));
    check_val({tag, "_dm_writes"}, 32'(dm_wr_cnt), 32'(DM));
    check_dump(tag);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_inrdy", 32'(in_ready), 32'd0);
    check_val("rst_cpurst", 32'(cpu_rst_n), 32'd0);
    check_val("rst_stall", 32'(cpu_stall), 32'd1);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_timeout", 32'(timeout), 32'd0);
    check_val("rst_outvld", 32'(out_valid), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_val("idle_busy", 32'(busy), 32'd0);

    // Budget expiry, then halt mid-run with a stray start, then halt on the last budget cycle
    do_run(-1, RC, 1'b1, "to", 1'b0);
    do_run(5, 6, 1'b0, "h5", 1'b1);
    do_run(RC - 1, RC, 1'b0, "h19", 1'b0);

    // Reset during LOAD_DM after three data bytes
    halt_at = -1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    stream(IM + 3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("mrst_inrdy", 32'(in_ready), 32'd0);
    check_val("mrst_cpurst", 32'(cpu_rst_n), 32'd0);
    check_val("mrst_busy", 32'(busy), 32'd0);
    check_val("mrst_stall", 32'(cpu_stall), 32'd1);
    do_run(-1, RC, 1'b1, "rerun", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
